// File: rtl/md_sched.sv
// Issue/completion scheduler for the multiply/divide unit: launches an operation,
// holds busy for a fixed latency, strobes the HI/LO commit and stalls decode.
module md_sched #(
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] md_op_E,
  input  logic       md_use_D,
  input  logic       flush,
  output logic       start,
  output logic [1:0] md_sel,
  output logic       busy,
  output logic       hilo_we,
  output logic       stall_D,
  output logic       err
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [3:0] MULT_CNT = MULT_LAT[3:0];
  localparam logic [3:0] DIV_CNT  = DIV_LAT[3:0];

  logic [0:0] state;
  logic [3:0] cnt;
  logic       launch_op;
  logic       md_op;

  always_comb begin
    launch_op = (md_op_E >= 4'd1) && (md_op_E <= 4'd4);
    md_op     = (md_op_E >= 4'd1) && (md_op_E <= 4'd8);
  end

  // start is gated by reset so nothing escapes combinationally while reset is held
  assign start   = !reset && (state == IDLE) && launch_op && !flush;
  assign busy    = (state == RUN);
  assign hilo_we = (state == RUN) && (cnt == 4'd1) && !flush;
  assign stall_D = md_use_D && (start || busy);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      md_sel <= '0;
      err    <= 1'b0;
    end else begin
      if ((state == RUN) && md_op)
        err <= 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            state  <= RUN;
            // low two opcode bits minus one map 1..4 onto 0..3 (4 wraps 00 -> 11)
            md_sel <= md_op_E[1:0] - 2'd1;
            cnt    <= (md_op_E <= 4'd2) ? MULT_CNT : DIV_CNT;
          end
        end
        RUN: begin
          if (flush || (cnt == 4'd1)) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_sched.sv
// Directed bench for md_sched: stimulus queues expected launch/commit events and
// per-cycle output snapshots; a negedge monitor pops and compares them.
module tb_md_sched;

  logic       clk;
  logic       reset;
  logic [3:0] md_op_E;
  logic       md_use_D;
  logic       flush;
  logic       start;
  logic [1:0] md_sel;
  logic       busy;
  logic       hilo_we;
  logic       stall_D;
  logic       err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int b;

  typedef struct {
    bit        commit;
    int        cyc;
    logic [1:0] sel;
  } ev_t;

  typedef struct {
    int        cyc;
    bit        start;
    bit        busy;
    bit        hilo;
    bit        stall;
    bit        err;
    logic [1:0] sel;
  } snap_t;

  ev_t   evq[$];
  snap_t snapq[$];
  ev_t   e;
  snap_t s;

  md_sched #(.MULT_LAT(5), .DIV_LAT(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .md_op_E  (md_op_E),
    .md_use_D (md_use_D),
    .flush    (flush),
    .start    (start),
    .md_sel   (md_sel),
    .busy     (busy),
    .hilo_we  (hilo_we),
    .stall_D  (stall_D),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ev(input bit commit, input int c, input logic [1:0] sel);
    ev_t x;
    x.commit = commit; x.cyc = c; x.sel = sel;
    evq.push_back(x);
  endtask

  task automatic snap(input int c, input bit st, input bit bz, input bit hw,
                      input bit sd, input bit er, input logic [1:0] sel);
    snap_t x;
    x.cyc = c; x.start = st; x.busy = bz; x.hilo = hw; x.stall = sd; x.err = er; x.sel = sel;
    snapq.push_back(x);
  endtask

  // Monitor: launch/commit events and scheduled snapshots
  always @(negedge clk) begin
    if (start || hilo_we) begin
      checks++;
      if (evq.size() == 0) begin
        errors++;
        $display("FAIL event: unexpected start=%0b hilo_we=%0b at cycle %0d", start, hilo_we, cyc);
      end else begin
        e = evq.pop_front();
        if ((e.commit != hilo_we) || (e.cyc != cyc) || (e.commit && (e.sel != md_sel))) begin
          errors++;
          $display("FAIL event: got commit=%0b cycle=%0d md_sel=%0d, want commit=%0b cycle=%0d md_sel=%0d",
                   hilo_we, cyc, md_sel, e.commit, e.cyc, e.sel);
        end
      end
    end
    if (snapq.size() != 0) begin
      if (snapq[0].cyc < cyc) begin
        s = snapq.pop_front();
        checks++;
        errors++;
        $display("FAIL snap: snapshot for cycle %0d missed, now cycle %0d", s.cyc, cyc);
      end else if (snapq[0].cyc == cyc) begin
        s = snapq.pop_front();
        checks++;
        if ((start !== s.start) || (busy !== s.busy) || (hilo_we !== s.hilo) ||
            (stall_D !== s.stall) || (err !== s.err) || (md_sel !== s.sel)) begin
          errors++;
          $display("FAIL snap@%0d: start/busy/hilo_we/stall_D/err/md_sel got %b %b %b %b %b %0d want %b %b %b %b %b %0d",
                   cyc, start, busy, hilo_we, stall_D, err, md_sel,
                   s.start, s.busy, s.hilo, s.stall, s.err, s.sel);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; md_op_E = 4'd1; md_use_D = 1'b1; flush = 1'b0;
    tick();
    // reset held with a launch opcode and md_use_D present: everything quiet
    snap(cyc, 0, 0, 0, 0, 0, 2'd0);
    tick();
    reset = 1'b0; md_op_E = 4'd0; md_use_D = 1'b0;
    tick();

    // mult: start at b, busy b+1..b+5, commit at b+5, idle at b+6
    b = cyc; md_op_E = 4'd1;
    ev(0, b, 2'd0); ev(1, b+5, 2'd0);
    snap(b, 1, 0, 0, 0, 0, 2'd0);
    snap(b+1, 0, 1, 0, 0, 0, 2'd0);
    snap(b+5, 0, 1, 1, 0, 0, 2'd0);
    snap(b+6, 0, 0, 0, 0, 0, 2'd0);
    tick(); md_op_E = 4'd0;
    repeat (6) tick();

    // divu with md_use_D held: stall b..b+10, commit at b+10
    b = cyc; md_op_E = 4'd4; md_use_D = 1'b1;
    ev(0, b, 2'd0); ev(1, b+10, 2'd3);
    snap(b, 1, 0, 0, 1, 0, 2'd0);
    snap(b+1, 0, 1, 0, 1, 0, 2'd3);
    snap(b+10, 0, 1, 1, 1, 0, 2'd3);
    snap(b+11, 0, 0, 0, 0, 0, 2'd3);
    tick(); md_op_E = 4'd0;
    repeat (10) tick();
    md_use_D = 1'b0;
    tick();

    // div flushed at b+4
    b = cyc; md_op_E = 4'd3;
    ev(0, b, 2'd0);
    snap(b, 1, 0, 0, 0, 0, 2'd3);
    snap(b+4, 0, 1, 0, 0, 0, 2'd2);
    snap(b+5, 0, 0, 0, 0, 0, 2'd2);
    tick(); md_op_E = 4'd0;
    repeat (3) tick();
    flush = 1'b1;
    tick(); flush = 1'b0;
    tick();

    // mult flushed in its final cycle: commit suppressed
    b = cyc; md_op_E = 4'd1;
    ev(0, b, 2'd0);
    snap(b, 1, 0, 0, 0, 0, 2'd2);
    snap(b+5, 0, 1, 0, 0, 0, 2'd0);
    snap(b+6, 0, 0, 0, 0, 0, 2'd0);
    tick(); md_op_E = 4'd0;
    repeat (4) tick();
    flush = 1'b1;
    tick(); flush = 1'b0;
    tick();

    // flush arriving with a launch opcode wins
    b = cyc; md_op_E = 4'd2; flush = 1'b1;
    snap(b, 0, 0, 0, 0, 0, 2'd0);
    snap(b+1, 0, 0, 0, 0, 0, 2'd0);
    tick(); md_op_E = 4'd0; flush = 1'b0;
    tick();

    // mult, then multu while busy: ignored, err sticky; then mfhi and op 12 in IDLE
    b = cyc; md_op_E = 4'd1;
    ev(0, b, 2'd0); ev(1, b+5, 2'd0);
    snap(b, 1, 0, 0, 0, 0, 2'd0);
    snap(b+2, 0, 1, 0, 0, 0, 2'd0);
    snap(b+3, 0, 1, 0, 0, 1, 2'd0);
    snap(b+5, 0, 1, 1, 0, 1, 2'd0);
    snap(b+6, 0, 0, 0, 0, 1, 2'd0);
    snap(b+7, 0, 0, 0, 0, 1, 2'd0);
    tick(); md_op_E = 4'd0;
    tick(); md_op_E = 4'd2;
    tick(); md_op_E = 4'd0;
    repeat (3) tick();
    md_op_E = 4'd7;
    tick(); md_op_E = 4'd12;
    tick(); md_op_E = 4'd0;

    // mult then div issued the cycle after the commit
    b = cyc; md_op_E = 4'd1;
    ev(0, b, 2'd0); ev(1, b+5, 2'd0); ev(0, b+6, 2'd0); ev(1, b+16, 2'd2);
    snap(b+5, 0, 1, 1, 0, 1, 2'd0);
    snap(b+6, 1, 0, 0, 0, 1, 2'd0);
    snap(b+7, 0, 1, 0, 0, 1, 2'd2);
    snap(b+16, 0, 1, 1, 0, 1, 2'd2);
    snap(b+17, 0, 0, 0, 0, 1, 2'd2);
    tick(); md_op_E = 4'd0;
    repeat (5) tick();
    md_op_E = 4'd3;
    tick(); md_op_E = 4'd0;
    repeat (10) tick();
    tick();

    // reset mid-RUN aborts without commit; the next op launches from IDLE
    b = cyc; md_op_E = 4'd1;
    ev(0, b, 2'd0); ev(0, b+3, 2'd0); ev(1, b+13, 2'd2);
    snap(b, 1, 0, 0, 0, 1, 2'd2);
    snap(b+1, 0, 1, 0, 0, 1, 2'd0);
    snap(b+2, 0, 0, 0, 0, 0, 2'd0);
    snap(b+3, 1, 0, 0, 0, 0, 2'd0);
    snap(b+4, 0, 1, 0, 0, 0, 2'd2);
    snap(b+13, 0, 1, 1, 0, 0, 2'd2);
    snap(b+14, 0, 0, 0, 0, 0, 2'd2);
    tick(); md_op_E = 4'd0;
    tick(); reset = 1'b1;
    tick(); reset = 1'b0; md_op_E = 4'd3;
    tick(); md_op_E = 4'd0;
    repeat (10) tick();
    tick();
    tick();

    checks++;
    if (evq.size() != 0) begin
      errors++;
      $display("FAIL events_left: got %0d pending, want 0", evq.size());
    end
    checks++;
    if (snapq.size() != 0) begin
      errors++;
      $display("FAIL snaps_left: got %0d pending, want 0", snapq.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
